// File: rtl/axi4_rd_stream_pkg.sv
// Shared types and AXI constants for the axi4_rd_stream read master.
package axi4_rd_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned WORDS_4KB      = 1024;

  // Largest burst that fits the beat limit, the words left, and the current 4KB page.
  function automatic logic [31:0] burst_words(input logic [9:0]  page_word,
                                              input logic [23:0] remaining,
                                              input int unsigned max_len);
    logic [31:0] page_left;
    logic [31:0] len;
    page_left = WORDS_4KB - {22'b0, page_word};
    len       = max_len;
    if ({8'b0, remaining} < len) len = {8'b0, remaining};
    if (page_left < len)         len = page_left;
    return len;
  endfunction

endpackage

// File: rtl/axi4_rd_stream_fifo.sv
// Word FIFO with registered head output and occupancy level.
module stream_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic                   valid_o,
  output logic [WIDTH-1:0]       data_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             do_push;
  logic             do_pop;
  logic [WIDTH-1:0] head_d;

  always_comb begin
    do_pop   = pop_i && (level_q != '0);
    do_push  = push_i && ((level_q != LVL_W'(DEPTH)) || do_pop);
    level_d  = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    // The output register looks ahead: if the FIFO would otherwise be empty, the pushed word becomes the head.
    if (do_push && ((level_q - LVL_W'(do_pop)) == '0)) head_d = push_data_i;
    else                                                head_d = mem[rd_ptr_d];
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_o  <= 1'b0;
      data_o   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(do_push);
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_o  <= (level_d != '0);
      if (level_d != '0) data_o <= head_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/axi4_rd_stream.sv
// AXI4 read burst master: fetches a linear word region and streams it out, credit-limited by FIFO space.
module axi4_rd_stream
  import axi4_rd_stream_pkg::*;
#(
  parameter int unsigned AXI_ID     = 0,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  input  logic [23:0] word_count_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        outport_arvalid_o,
  output logic [31:0] outport_araddr_o,
  output logic [3:0]  outport_arid_o,
  output logic [7:0]  outport_arlen_o,
  output logic [1:0]  outport_arburst_o,
  input  logic        outport_arready_i,
  input  logic        outport_rvalid_i,
  input  logic [31:0] outport_rdata_i,
  input  logic [1:0]  outport_rresp_i,
  input  logic [3:0]  outport_rid_i,
  input  logic        outport_rlast_i,
  output logic        outport_rready_o,
  output logic        data_valid_o,
  output logic [31:0] data_o,
  input  logic        data_ready_i
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [23:0]      rem_q, rem_d;
  logic [23:0]      total_q, total_d;
  logic [23:0]      deliv_q, deliv_d;
  logic [LVL_W-1:0] out_q, out_d;
  logic             arvalid_q, arvalid_d;
  logic [31:0]      araddr_q, araddr_d;
  logic [7:0]       arlen_q, arlen_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             rready_q;

  logic             ar_hs;
  logic             r_hs;
  logic             pop;
  logic [8:0]       ar_beats;
  logic [31:0]      burst_len;
  logic [31:0]      credit;
  logic [LVL_W-1:0] fifo_level;
  logic             fifo_valid;
  logic             unused_ok;

  assign ar_hs    = arvalid_q && outport_arready_i;
  assign r_hs     = outport_rvalid_i && rready_q;
  assign pop      = fifo_valid && data_ready_i;
  assign ar_beats = {1'b0, arlen_q} + 9'd1;

  always_comb begin
    burst_len = burst_words(addr_q[11:2], rem_q, BURST_LEN);
    // Words already buffered or still owed by the slave both consume FIFO space.
    credit    = FIFO_DEPTH - 32'(fifo_level) - 32'(out_q);
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    total_d   = total_q;
    deliv_d   = deliv_q + 24'(pop);
    out_d     = out_q + (ar_hs ? LVL_W'(ar_beats) : '0) - LVL_W'(r_hs);
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    err_d     = err_q || (r_hs && (outport_rresp_i != AXI_RESP_OKAY));
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d  = {base_addr_i[31:2], 2'b00};
          rem_d   = word_count_i;
          total_d = word_count_i;
          deliv_d = '0;
          err_d   = 1'b0;
          state_d = (word_count_i == '0) ? ST_DRAIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (arvalid_q) begin
          if (outport_arready_i) begin
            arvalid_d = 1'b0;
            addr_d    = addr_q + {21'b0, ar_beats, 2'b00};
            rem_d     = rem_q - {15'b0, ar_beats};
            if (rem_q == {15'b0, ar_beats}) state_d = ST_DRAIN;
          end
        end else if (credit >= burst_len) begin
          arvalid_d = 1'b1;
          araddr_d  = addr_q;
          arlen_d   = 8'(burst_len - 32'd1);
        end
      end
      ST_DRAIN: begin
        if (deliv_d == total_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      total_q   <= '0;
      deliv_q   <= '0;
      out_q     <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      total_q   <= total_d;
      deliv_q   <= deliv_d;
      out_q     <= out_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      err_q     <= err_d;
      done_q    <= done_d;
      rready_q  <= 1'b1;
    end
  end

  stream_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (r_hs),
    .push_data_i (outport_rdata_i),
    .pop_i       (pop),
    .valid_o     (fifo_valid),
    .data_o      (data_o),
    .level_o     (fifo_level)
  );

  assign busy_o            = (state_q != ST_IDLE);
  assign done_o            = done_q;
  assign error_o           = err_q;
  assign outport_arvalid_o = arvalid_q;
  assign outport_araddr_o  = araddr_q;
  assign outport_arid_o    = 4'(AXI_ID);
  assign outport_arlen_o   = arlen_q;
  assign outport_arburst_o = AXI_BURST_INCR;
  assign outport_rready_o  = rready_q;
  assign data_valid_o      = fifo_valid;

  // Single-ID, in-order slave: rid/rlast carry no information here.
  assign unused_ok = ^{outport_rid_i, outport_rlast_i, base_addr_i[1:0]};

endmodule

// File: tb/tb_axi4_rd_stream.sv
// Randomized bench for axi4_rd_stream with an AXI slave model and a burst/word reference model.
module tb_axi4_rd_stream;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [23:0] word_count_i;
  logic        busy_o, done_o, error_o;
  logic        arvalid_o;
  logic [31:0] araddr_o;
  logic [3:0]  arid_o;
  logic [7:0]  arlen_o;
  logic [1:0]  arburst_o;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;
  logic        rready_o;
  logic        data_valid_o;
  logic [31:0] data_o;
  logic        data_ready;

  axi4_rd_stream #(
    .AXI_ID(0),
    .BURST_LEN(16),
    .FIFO_DEPTH(64)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .start_i           (start_i),
    .base_addr_i       (base_addr_i),
    .word_count_i      (word_count_i),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .error_o           (error_o),
    .outport_arvalid_o (arvalid_o),
    .outport_araddr_o  (araddr_o),
    .outport_arid_o    (arid_o),
    .outport_arlen_o   (arlen_o),
    .outport_arburst_o (arburst_o),
    .outport_arready_i (arready),
    .outport_rvalid_i  (rvalid),
    .outport_rdata_i   (rdata),
    .outport_rresp_i   (rresp),
    .outport_rid_i     (rid),
    .outport_rlast_i   (rlast),
    .outport_rready_o  (rready_o),
    .data_valid_o      (data_valid_o),
    .data_o            (data_o),
    .data_ready_i      (data_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  ar_t         exp_ar[$];
  logic [31:0] beat_q[$];
  logic [31:0] exp_base;
  int unsigned exp_cnt      = 0;
  int unsigned words_seen   = 0;
  int unsigned ar_seen      = 0;
  int unsigned beats_sent   = 0;
  int unsigned issued_beats = 0;
  int unsigned done_cnt     = 0;
  int          err_beat     = -1;
  bit          rand_mode    = 0;
  int unsigned ar_dly       = 0;
  int unsigned ready_hold   = 0;
  bit          ar_busy      = 0;
  logic [31:0] ar_hold_addr;
  logic [7:0]  ar_hold_len;
  int unsigned ar_wait      = 0;
  bit          expect_done_next = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a >> 2) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Reference burst split: at most 16 beats, never past the words left or the end of a 4KB page.
  function automatic void plan_bursts(input logic [31:0] base, input int unsigned cnt);
    logic [31:0] a;
    int unsigned rem, len, room;
    exp_ar.delete();
    a   = {base[31:2], 2'b00};
    rem = cnt;
    while (rem > 0) begin
      room = 1024 - ((a >> 2) % 1024);
      len  = 16;
      if (rem < len)  len = rem;
      if (room < len) len = room;
      exp_ar.push_back('{addr: a, len: 8'(len - 1)});
      a   += 4 * len;
      rem -= len;
    end
  endfunction

  // Slave, consumer and done monitor; decides at each falling edge what the next rising edge will see.
  initial begin
    logic [31:0] a;
    ar_t         e;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        arready = 1'b0;
        rvalid  = 1'b0;
        ar_busy = 0;
        beat_q.delete();
        continue;
      end
      if (expect_done_next) begin
        check("done_timing", {31'b0, done_o}, 32'd1);
        expect_done_next = 0;
      end
      if (done_o) begin
        done_cnt++;
        check("busy_at_done", {31'b0, busy_o}, 32'd0);
      end

      rvalid = 1'b0;
      rresp  = 2'b00;
      rlast  = 1'b0;
      if (beat_q.size() != 0 && (!rand_mode || $urandom_range(3) != 0)) begin
        a      = beat_q.pop_front();
        rvalid = 1'b1;
        rdata  = mem_word(a);
        rresp  = (int'(beats_sent) == err_beat) ? 2'b10 : 2'b00;
        rlast  = (beat_q.size() == 0);
        check("rready", {31'b0, rready_o}, 32'd1);
        beats_sent++;
      end

      arready = 1'b0;
      if (arvalid_o) begin
        if (!ar_busy) begin
          ar_busy      = 1;
          ar_hold_addr = araddr_o;
          ar_hold_len  = arlen_o;
          ar_wait      = ar_dly;
        end else begin
          check("ar_addr_stable", araddr_o, ar_hold_addr);
          check("ar_len_stable", {24'b0, arlen_o}, {24'b0, ar_hold_len});
        end
        if (ar_wait == 0) begin
          arready = 1'b1;
          ar_busy = 0;
          ar_seen++;
          if (exp_ar.size() != 0) begin
            e = exp_ar.pop_front();
            check("araddr", araddr_o, e.addr);
            check("arlen", {24'b0, arlen_o}, {24'b0, e.len});
            check("arburst", {30'b0, arburst_o}, 32'd1);
            check("arid", {28'b0, arid_o}, 32'd0);
          end
          for (int unsigned i = 0; i <= 32'(arlen_o); i++) beat_q.push_back(araddr_o + 4 * i);
          issued_beats += 32'(arlen_o) + 1;
          check("credit", {31'b0, (issued_beats - words_seen) <= 64}, 32'd1);
        end else begin
          ar_wait--;
        end
      end

      if (ready_hold != 0) begin
        data_ready = 1'b0;
        ready_hold--;
      end else begin
        data_ready = rand_mode ? ($urandom_range(3) != 0) : 1'b1;
      end
      if (data_valid_o && data_ready) begin
        if (words_seen < exp_cnt) check("data", data_o, mem_word(exp_base + 4 * words_seen));
        words_seen++;
        if (words_seen == exp_cnt) expect_done_next = 1;
      end
    end
  end

  task automatic run_xfer(input logic [31:0] base, input int unsigned cnt, input int unsigned dly,
                          input int unsigned hold, input int eb, input bit rnd,
                          input int unsigned abort_after);
    int unsigned cyc;
    int unsigned n_planned;
    plan_bursts(base, cnt);
    n_planned        = exp_ar.size();
    exp_base         = {base[31:2], 2'b00};
    exp_cnt          = cnt;
    words_seen       = 0;
    ar_seen          = 0;
    beats_sent       = 0;
    issued_beats     = 0;
    done_cnt         = 0;
    err_beat         = eb;
    rand_mode        = rnd;
    ar_dly           = dly;
    ready_hold       = hold;
    expect_done_next = 0;

    @(negedge clk); #1;
    start_i      = 1'b1;
    base_addr_i  = base;
    word_count_i = cnt[23:0];
    @(negedge clk); #1;
    start_i = 1'b0;
    check("busy_after_start", {31'b0, busy_o}, 32'd1);
    check("error_cleared", {31'b0, error_o}, 32'd0);

    if (abort_after != 0) begin
      repeat (abort_after) @(negedge clk);
      #1 rst_i = 1'b1;
      #1;
      check("rst_arvalid", {31'b0, arvalid_o}, 32'd0);
      check("rst_araddr", araddr_o, 32'd0);
      check("rst_arlen", {24'b0, arlen_o}, 32'd0);
      check("rst_arburst", {30'b0, arburst_o}, 32'd1);
      check("rst_arid", {28'b0, arid_o}, 32'd0);
      check("rst_rready", {31'b0, rready_o}, 32'd0);
      check("rst_data_valid", {31'b0, data_valid_o}, 32'd0);
      check("rst_data", data_o, 32'd0);
      check("rst_busy", {31'b0, busy_o}, 32'd0);
      check("rst_done", {31'b0, done_o}, 32'd0);
      check("rst_error", {31'b0, error_o}, 32'd0);
      exp_cnt          = 0;
      expect_done_next = 0;
      exp_ar.delete();
      repeat (2) @(negedge clk);
      #1 rst_i = 1'b0;
      repeat (2) @(negedge clk);
      return;
    end

    cyc = 0;
    while (done_cnt == 0 && cyc < 5000) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("done_seen", {31'b0, done_cnt != 0}, 32'd1);
    if (cnt == 0) check("zero_done_latency", cyc, 32'd1);
    repeat (5) @(negedge clk);
    #1;
    check("done_once", done_cnt, 32'd1);
    check("word_total", words_seen, cnt);
    check("ar_total", ar_seen, n_planned);
    check("error_flag", {31'b0, error_o}, {31'b0, (eb >= 0) && (eb < int'(cnt))});
    check("busy_idle", {31'b0, busy_o}, 32'd0);
    check("stream_empty", {31'b0, data_valid_o}, 32'd0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    logic [31:0] b;
    int unsigned c;
    int          eb;
    rst_i        = 1'b1;
    start_i      = 1'b0;
    base_addr_i  = '0;
    word_count_i = '0;
    arready      = 1'b0;
    rvalid       = 1'b0;
    rdata        = '0;
    rresp        = 2'b00;
    rid          = 4'd0;
    rlast        = 1'b0;
    data_ready   = 1'b0;
    repeat (3) @(negedge clk);
    check("init_busy", {31'b0, busy_o}, 32'd0);
    check("init_arvalid", {31'b0, arvalid_o}, 32'd0);
    check("init_arburst", {30'b0, arburst_o}, 32'd1);
    check("init_rready", {31'b0, rready_o}, 32'd0);
    check("init_data_valid", {31'b0, data_valid_o}, 32'd0);
    #1 rst_i = 1'b0;
    repeat (2) @(negedge clk);

    run_xfer(32'h0000_1000, 40, 0, 0, -1, 0, 0);
    run_xfer(32'h0000_0FF8, 8, 0, 0, -1, 0, 0);
    run_xfer(32'h0000_2000, 200, 0, 400, -1, 0, 0);
    run_xfer(32'h0000_3004, 50, 5, 0, -1, 1, 0);
    run_xfer(32'h0000_4000, 30, 0, 0, 3, 1, 0);
    run_xfer(32'h0000_5000, 0, 0, 0, -1, 0, 0);

    for (int unsigned t = 0; t < 8; t++) begin
      b  = (32'($urandom_range(1, 15)) << 12) - 32'(4 * $urandom_range(0, 40)) + 32'($urandom_range(0, 3));
      c  = $urandom_range(1, 120);
      eb = ($urandom_range(3) == 0) ? int'($urandom_range(0, c - 1)) : -1;
      run_xfer(b, c, $urandom_range(0, 3), $urandom_range(0, 30), eb, 1, 0);
    end

    run_xfer(32'h0000_6000, 120, 0, 0, -1, 1, 40);
    run_xfer(32'h0000_7FC0, 37, 1, 0, -1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
